fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the SISC control FSM.
- Holds the program counter (PC) and instruction register (IR), and fetches from instruction memory using a req/valid handshake that tolerates wait states.
- Drives decoded IR fields (opcode, mm, register indices, immediate) to the controller and datapath.
- Applies PC updates for the branch opcodes, evaluating the branch condition against the status flags.

Parameters:
- PC_W, 16, program counter and instruction-address width.
- INSTR_W, 32, instruction width. The field map below is fixed for 32.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_f  input  1  asynchronous active-low reset.
- fetch_start  input  1  one-cycle pulse from the controller requesting the next instruction.
- br_update  input  1  one-cycle pulse from the controller (execute state) to evaluate the branch held in IR.
- stat  input  4  status flags from the status register.
- imem_req  output  1  instruction-memory request; held high until accepted.
- imem_addr  output  PC_W  instruction address; equals the PC while imem_req is high.
- imem_data  input  INSTR_W  instruction word; valid when imem_valid is high.
- imem_valid  input  1  memory response strobe; sampled only while imem_req is high.
- fetch_done  output  1  one-cycle pulse: IR loaded and PC incremented.
- busy  output  1  high in the REQ state.
- opcode  output  4  IR[31:28].
- mm  output  4  IR[27:24].
- rd  output  4  IR[23:20].
- rs  output  4  IR[19:16].
- rt  output  4  IR[15:12].
- imm  output  16  IR[15:0].
- pc  output  PC_W  current PC.
- br_taken  output  1  registered; high for one cycle after a br_update that changed the PC.
- br_ignored  output  1  registered; high for one cycle after a br_update arrived while busy.

Behaviour:
- Reset (rst_f low, asynchronous):
  - pc=RESET_PC, IR=0 (so opcode reads NOOP), state=IDLE.
  - imem_req, fetch_done, br_taken, br_ignored all 0.
  - A reset during REQ aborts the fetch; imem_req falls without waiting for a clock edge. Any later imem_valid is ignored.
- States: IDLE and REQ only.
- IDLE, fetch_start=1: go to REQ next cycle. imem_req=1 and imem_addr=pc are combinational from the state and PC.
- REQ, imem_valid=0: stay in REQ; imem_req and imem_addr held stable, for any number of wait cycles.
- REQ, imem_valid=1 at a posedge:
  - IR<=imem_data and pc<=pc+1 (wraps 2^PC_W-1 -> 0).
  - fetch_done=1 for exactly the following cycle; return to IDLE.
  - Minimum latency from fetch_start to fetch_done is 2 cycles.
- fetch_start while in REQ: ignored (no queueing).
- br_update in IDLE: evaluate the instruction in IR, where cond = ((stat & mm) != 4'b0000).
  - BRA (4): if cond, pc<=imm[PC_W-1:0].
  - BRR (5): if cond, pc<=pc+sign_extend(imm), modulo 2^PC_W.
  - BNE (6): if !cond, pc<=imm[PC_W-1:0].
  - BNR (7): if !cond, pc<=pc+sign_extend(imm).
  - Any other opcode: no PC change.
  - br_taken=1 on the next cycle only if the PC was written.
- br_update in REQ: ignored; PC unchanged; br_ignored=1 on the next cycle.
- Relative-branch base: the PC after the increment, i.e. branch address + 1.
- Simultaneous br_update and fetch_start in IDLE:
  - The branch updates the PC at that posedge and the state moves to REQ.
  - imem_addr in REQ therefore shows the branched PC.
- IR-derived outputs change only on a fetch completion or on reset.

Test Plan:
- Reset, then fetch_start; memory returns 32'h1_1_2_3_0005 after 0 wait cycles -> imem_addr=0, fetch_done 2 cycles after start, opcode=1, mm=1, rd=2, rs=3, imm=16'h0005, pc=1.
- imem_valid delayed 3 cycles -> imem_req and imem_addr=0 held for 4 cycles, exactly one fetch_done pulse, pc=1.
- IR=BRA (mm=4'b0010, imm=16'h0040), stat=4'b0010, br_update -> pc=16'h0040, br_taken=1. Repeat with stat=4'b0000 -> pc unchanged, br_taken=0.
- IR=BNR at address 9 (pc=10), imm=16'hFFFC, stat & mm = 0, br_update -> pc=6, br_taken=1.
- Wrap: pc=16'hFFFF, complete a fetch -> pc=0. br_update during REQ -> br_ignored=1, pc unaffected.
- rst_f low mid-REQ (before imem_valid) -> imem_req=0 immediately, pc=0, IR=0, no fetch_done. A late imem_valid is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, fetches over a req/valid handshake
// with arbitrary wait states, and resolves the four conditional branch opcodes.
module fetch_unit #(
   parameter int unsigned      PC_W     = 16,
   parameter int unsigned      INSTR_W  = 32,
   parameter logic [PC_W-1:0]  RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_f,
   input  logic               fetch_start,
   input  logic               br_update,
   input  logic [3:0]         stat,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               imem_valid,
   output logic               fetch_done,
   output logic               busy,
   output logic [3:0]         opcode,
   output logic [3:0]         mm,
   output logic [3:0]         rd,
   output logic [3:0]         rs,
   output logic [3:0]         rt,
   output logic [15:0]        imm,
   output logic [PC_W-1:0]    pc,
   output logic               br_taken,
   output logic               br_ignored
);

   localparam logic [3:0] OP_BRA = 4'd4;
   localparam logic [3:0] OP_BRR = 4'd5;
   localparam logic [3:0] OP_BNE = 4'd6;
   localparam logic [3:0] OP_BNR = 4'd7;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   state_t             state;
   logic [INSTR_W-1:0] ir;
   logic               cond;
   logic               br_hit;
   logic [PC_W-1:0]    br_target;

   assign opcode    = ir[31:28];
   assign mm        = ir[27:24];
   assign rd        = ir[23:20];
   assign rs        = ir[19:16];
   assign rt        = ir[15:12];
   assign imm       = ir[15:0];

   // Request and address come straight from state/PC so an async reset drops them at once
   assign imem_req  = (state == REQ);
   assign busy      = (state == REQ);
   assign imem_addr = pc;

   // Branch resolution for the instruction currently held in IR; relative base is the incremented PC
   always_comb begin
      cond      = ((stat & mm) != 4'b0000);
      br_hit    = 1'b0;
      br_target = pc;
      case (opcode)
         OP_BRA: begin br_hit = cond;  br_target = PC_W'(imm); end
         OP_BRR: begin br_hit = cond;  br_target = pc + PC_W'($signed(imm)); end
         OP_BNE: begin br_hit = !cond; br_target = PC_W'(imm); end
         OP_BNR: begin br_hit = !cond; br_target = pc + PC_W'($signed(imm)); end
         default: begin br_hit = 1'b0; br_target = pc; end
      endcase
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         ir         <= '0;
         fetch_done <= 1'b0;
         br_taken   <= 1'b0;
         br_ignored <= 1'b0;
      end else begin
         fetch_done <= 1'b0;
         br_taken   <= 1'b0;
         br_ignored <= 1'b0;
         case (state)
            IDLE: begin
               if (br_update && br_hit) begin
                  pc       <= br_target;
                  br_taken <= 1'b1;
               end
               if (fetch_start) state <= REQ;
            end
            REQ: begin
               if (br_update) br_ignored <= 1'b1;
               if (imem_valid) begin
                  ir         <= imem_data;
                  pc         <= pc + PC_W'(1);
                  fetch_done <= 1'b1;
                  state      <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// fetch/branch sequences checked against an arithmetic reference model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_f;
   logic        fetch_start;
   logic        br_update;
   logic [3:0]  stat;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [31:0] imem_data;
   logic        imem_valid;
   logic        fetch_done;
   logic        busy;
   logic [3:0]  opcode, mm, rd, rs, rt;
   logic [15:0] imm;
   logic [15:0] pc;
   logic        br_taken;
   logic        br_ignored;

   int tests = 0;
   int fails = 0;

   // Reference model state
   int          m_pc = 0;
   logic [31:0] m_ir = '0;

   fetch_unit #(.PC_W(16), .INSTR_W(32), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_f(rst_f), .fetch_start(fetch_start), .br_update(br_update),
      .stat(stat), .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
      .imem_valid(imem_valid), .fetch_done(fetch_done), .busy(busy), .opcode(opcode),
      .mm(mm), .rd(rd), .rs(rs), .rt(rt), .imm(imm), .pc(pc),
      .br_taken(br_taken), .br_ignored(br_ignored)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Branch outcome straight from the opcode table, using integer arithmetic
   task automatic ref_branch(input logic [31:0] ir, input logic [3:0] st,
                             output bit taken, output int npc);
      int  op;
      int  off;
      bit  cond;
      op   = int'(ir[31:28]);
      cond = ((st & ir[27:24]) != 4'd0);
      off  = int'(ir[15:0]);
      if (off >= 32768) off -= 65536;
      taken = 1'b0;
      npc   = m_pc;
      if ((op == 4 && cond) || (op == 6 && !cond)) begin
         taken = 1'b1; npc = int'(ir[15:0]);
      end else if ((op == 5 && cond) || (op == 7 && !cond)) begin
         taken = 1'b1; npc = (m_pc + off + 65536) % 65536;
      end
   endtask

   task automatic check_fields(input string tag);
      chk({tag, ".pc"},     32'(pc),     32'(m_pc));
      chk({tag, ".opcode"}, 32'(opcode), 32'(m_ir[31:28]));
      chk({tag, ".mm"},     32'(mm),     32'(m_ir[27:24]));
      chk({tag, ".rd"},     32'(rd),     32'(m_ir[23:20]));
      chk({tag, ".rs"},     32'(rs),     32'(m_ir[19:16]));
      chk({tag, ".rt"},     32'(rt),     32'(m_ir[15:12]));
      chk({tag, ".imm"},    32'(imm),    32'(m_ir[15:0]));
   endtask

   // Called at a negedge while in REQ: respond with data, then check the completion
   task automatic finish_req(input logic [31:0] data);
      imem_valid = 1'b1;
      imem_data  = data;
      @(negedge clk);
      imem_valid = 1'b0;
      imem_data  = $urandom;
      m_ir = data;
      m_pc = (m_pc + 1) % 65536;
      chk("done_pulse", 32'(fetch_done), 32'd1);
      chk("req_drop",   32'(imem_req),   32'd0);
      check_fields("fetch");
      @(negedge clk);
      chk("done_once",  32'(fetch_done), 32'd0);
      chk("idle_req",   32'(imem_req),   32'd0);
   endtask

   task automatic fetch(input logic [31:0] data, input int waits, input bit br_in_req);
      @(negedge clk);
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      chk("req_high", 32'(imem_req), 32'd1);
      chk("busy",     32'(busy),     32'd1);
      chk("req_addr", 32'(imem_addr), 32'(m_pc));
      if (br_in_req) begin
         br_update = 1'b1;
         stat      = 4'hF;
      end
      for (int i = 0; i < waits; i++) begin
         @(negedge clk);
         if (i == 0 && br_in_req) begin
            br_update = 1'b0;
            chk("br_ignored", 32'(br_ignored), 32'd1);
            chk("br_ign_nt",  32'(br_taken),   32'd0);
         end
         chk("wait_req",  32'(imem_req),   32'd1);
         chk("wait_addr", 32'(imem_addr),  32'(m_pc));
         chk("wait_done", 32'(fetch_done), 32'd0);
      end
      finish_req(data);
   endtask

   task automatic branch(input logic [3:0] st);
      bit taken;
      int npc;
      @(negedge clk);
      br_update = 1'b1;
      stat      = st;
      @(negedge clk);
      br_update = 1'b0;
      ref_branch(m_ir, st, taken, npc);
      m_pc = npc;
      chk("br_taken", 32'(br_taken),   32'(taken));
      chk("br_pc",    32'(pc),         32'(m_pc));
      chk("br_noign", 32'(br_ignored), 32'd0);
   endtask

   initial begin
      bit taken;
      int npc;
      rst_f = 1'b0; fetch_start = 1'b0; br_update = 1'b0; stat = 4'h0;
      imem_data = '0; imem_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pc",   32'(pc),         32'd0);
      chk("rst_op",   32'(opcode),     32'd0);
      chk("rst_req",  32'(imem_req),   32'd0);
      chk("rst_done", 32'(fetch_done), 32'd0);
      chk("rst_bt",   32'(br_taken),   32'd0);
      chk("rst_bi",   32'(br_ignored), 32'd0);
      rst_f = 1'b1;

      fetch(32'h1123_0005, 0, 1'b0);       // zero-wait fetch from address 0
      fetch(32'hA5A5_1234, 3, 1'b0);       // three wait states
      fetch(32'h4200_0040, 0, 1'b0);       // BRA mm=0010 imm=0040
      branch(4'b0010);                     // taken -> 0x40
      branch(4'b0000);                     // not taken
      fetch(32'h4F00_0009, 1, 1'b0);
      branch(4'hF);                        // pc=9
      fetch(32'h7000_FFFC, 0, 1'b0);       // BNR at 9, pc=10
      branch(4'h0);                        // pc=6
      fetch(32'h4F00_FFFF, 0, 1'b0);
      branch(4'hF);                        // pc=FFFF
      fetch(32'h0000_0000, 2, 1'b1);       // wrap to 0 with br_update ignored in REQ

      // Simultaneous branch and fetch_start: REQ address shows the branched PC
      fetch(32'h4F00_0123, 0, 1'b0);
      @(negedge clk);
      br_update = 1'b1; stat = 4'h1; fetch_start = 1'b1;
      @(negedge clk);
      br_update = 1'b0; fetch_start = 1'b0;
      ref_branch(m_ir, 4'h1, taken, npc);
      m_pc = npc;
      chk("sim_bt",   32'(br_taken),  32'(taken));
      chk("sim_req",  32'(imem_req),  32'd1);
      chk("sim_addr", 32'(imem_addr), 32'(m_pc));
      finish_req(32'h5123_00AB);

      // Randomized fetch/branch mix biased toward branch opcodes
      for (int n = 0; n < 40; n++) begin
         fetch({4'($urandom_range(0, 9)), 28'($urandom)}, int'($urandom_range(0, 3)), 1'b0);
         branch(4'($urandom_range(0, 15)));
      end

      // Reset in the middle of REQ aborts the fetch immediately
      @(negedge clk);
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      chk("mid_req", 32'(imem_req), 32'd1);
      #2 rst_f = 1'b0;
      #1;
      m_pc = 0; m_ir = '0;
      chk("arst_req", 32'(imem_req), 32'd0);
      chk("arst_pc",  32'(pc),       32'd0);
      chk("arst_op",  32'(opcode),   32'd0);
      @(negedge clk);
      rst_f = 1'b1;
      imem_valid = 1'b1;
      imem_data  = 32'hFFFF_FFFF;
      @(negedge clk);
      imem_valid = 1'b0;
      chk("late_done", 32'(fetch_done), 32'd0);
      chk("late_pc",   32'(pc),         32'd0);
      check_fields("late");
      chk("late_req",  32'(imem_req),   32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
